// File: rtl/wam_ctl.sv
// wam_ctl -- whack-a-mole game controller.
//
// Purpose: sequences the game through IDLE / GAP / SHOW / OVER, picks a hole
// for each mole from a free-running LFSR, detects hits from button rising
// edges, times moles out as misses, and tracks the difficulty level.
//
// Ports:
//   clk     in   system clock, rising edge
//   clr     in   asynchronous active-high reset
//   start   in   one-cycle start / restart request (IDLE and OVER only)
//   tick    in   one-cycle timebase enable
//   btn     in   [7:0] synchronized, debounced hole buttons (levels)
//   lvl_up  in   asynchronous level-up carry from the score counter
//   mole    out  [7:0] one-hot visible mole, 0 when none
//   hit     out  [7:0] one-clk pulse on the hit hole
//   miss    out  one-clk pulse on mole timeout
//   level   out  [1:0] current difficulty 0..3
//   busy    out  high in GAP / SHOW
//   over    out  high in OVER
module wam_ctl #(
  parameter int SHOW_T   = 800,
  parameter int GAP_T    = 200,
  parameter int MAX_MISS = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       tick,
  input  logic [7:0] btn,
  input  logic       lvl_up,
  output logic [7:0] mole,
  output logic [7:0] hit,
  output logic       miss,
  output logic [1:0] level,
  output logic       busy,
  output logic       over
);

  localparam int          MW     = $clog2(MAX_MISS + 1);
  localparam logic [9:0]  SHOW_L = 10'(SHOW_T);
  localparam logic [9:0]  GAP_L  = 10'(GAP_T);
  localparam logic [MW-1:0] MISS_L = MW'(MAX_MISS);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

  state_t          state_q, state_d;
  logic [9:0]      timer_q, timer_d;
  logic [9:0]      lim_q, lim_d;      // SHOW length latched at SHOW entry
  logic [7:0]      mole_q, mole_d;
  logic [7:0]      hit_q, hit_d;
  logic            miss_q, miss_d;
  logic [1:0]      level_q, level_d;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic [2:0]      prev_q, prev_d;
  logic [7:0]      lfsr_q;
  logic [7:0]      btn_q;
  logic            lv_s1_q, lv_s2_q, lv_s3_q;

  logic [7:0]      btn_rise;
  logic            lv_rise;
  logic            lfsr_fb;
  logic [2:0]      idx_new;
  logic [9:0]      timer_inc;
  logic [MW-1:0]   mcnt_inc;

  // Fibonacci LFSR, taps for x^8+x^6+x^5+x^4+1
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign btn_rise  = btn & ~btn_q;
  assign lv_rise   = lv_s2_q & ~lv_s3_q;
  // Never repeat the previous hole back to back
  assign idx_new   = (lfsr_q[2:0] == prev_q) ? lfsr_q[2:0] + 3'd1 : lfsr_q[2:0];
  assign timer_inc = timer_q + 10'd1;
  assign mcnt_inc  = mcnt_q + MW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lim_d   = lim_q;
    mole_d  = mole_q;
    hit_d   = '0;
    miss_d  = 1'b0;
    level_d = level_q;
    mcnt_d  = mcnt_q;
    prev_d  = prev_q;

    // Level may move only while a game is running; it reaches the SHOW
    // length only through lim_q at the next SHOW entry.
    if ((state_q == GAP || state_q == SHOW) && lv_rise && level_q != 2'd3)
      level_d = level_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GAP;
          timer_d = '0;
        end
      end
      GAP: begin
        if (tick) begin
          if (timer_inc == GAP_L) begin
            state_d = SHOW;
            timer_d = '0;
            mole_d  = 8'b1 << idx_new;
            prev_d  = idx_new;
            lim_d   = SHOW_L >> level_q;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      SHOW: begin
        // Hit is evaluated first so it wins over a simultaneous timeout
        if (|(btn_rise & mole_q)) begin
          hit_d   = mole_q;
          mole_d  = '0;
          state_d = GAP;
          timer_d = '0;
        end else if (tick) begin
          if (timer_inc == lim_q) begin
            miss_d  = 1'b1;
            mole_d  = '0;
            timer_d = '0;
            mcnt_d  = mcnt_inc;
            state_d = (mcnt_inc == MISS_L) ? OVER : GAP;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      OVER: begin
        mole_d = '0;
        if (start) begin
          state_d = GAP;
          timer_d = '0;
          mcnt_d  = '0;
          level_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      timer_q <= '0;
      lim_q   <= '0;
      mole_q  <= '0;
      hit_q   <= '0;
      miss_q  <= 1'b0;
      level_q <= 2'd0;
      mcnt_q  <= '0;
      prev_q  <= 3'd0;
      lfsr_q  <= 8'hA5;
      btn_q   <= '0;
      lv_s1_q <= 1'b0;
      lv_s2_q <= 1'b0;
      lv_s3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lim_q   <= lim_d;
      mole_q  <= mole_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      level_q <= level_d;
      mcnt_q  <= mcnt_d;
      prev_q  <= prev_d;
      lfsr_q  <= {lfsr_q[6:0], lfsr_fb};
      btn_q   <= btn;
      lv_s1_q <= lvl_up;
      lv_s2_q <= lv_s1_q;
      lv_s3_q <= lv_s2_q;
    end
  end

  assign mole  = mole_q;
  assign hit   = hit_q;
  assign miss  = miss_q;
  assign level = level_q;
  assign busy  = (state_q == GAP) || (state_q == SHOW);
  assign over  = (state_q == OVER);

endmodule

// File: tb/tb_wam_ctl.sv
// tb_wam_ctl -- directed self-checking bench for wam_ctl at default parameters.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_wam_ctl;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] btn = 8'h00;
  logic       lvl_up = 1'b0;
  logic [7:0] mole, hit;
  logic       miss, busy, over;
  logic [1:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  int hits_seen = 0;
  int miss_seen = 0;

  wam_ctl dut (
    .clk(clk), .clr(clr), .start(start), .tick(tick), .btn(btn),
    .lvl_up(lvl_up), .mole(mole), .hit(hit), .miss(miss),
    .level(level), .busy(busy), .over(over)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (hit != 8'h00) hits_seen++;
    if (miss) miss_seen++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n tick pulses, each one clock high followed by one clock low
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) cyc();
    n_cmp++; if (mole !== 8'h00) begin n_bad++; $display("FAIL reset_mole got %h want 00", mole); end
    n_cmp++; if (hit !== 8'h00) begin n_bad++; $display("FAIL reset_hit got %h want 00", hit); end
    n_cmp++; if (miss !== 1'b0) begin n_bad++; $display("FAIL reset_miss got %b want 0", miss); end
    n_cmp++; if (level !== 2'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0 || over !== 1'b0) begin n_bad++; $display("FAIL reset_busy_over got %b%b want 00", busy, over); end
    clr = 1'b0;
    cyc();
    tick_n(5);
    n_cmp++; if (busy !== 1'b0 || mole !== 8'h00) begin n_bad++; $display("FAIL idle_ignores_tick busy=%b mole=%h want 0/00", busy, mole); end
    $display("reset: done, idle holds without start");
  endtask

  task automatic test_show_entry();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || over !== 1'b0) begin n_bad++; $display("FAIL start_to_gap busy=%b over=%b want 1/0", busy, over); end
    tick_n(199);
    n_cmp++; if (mole !== 8'h00) begin n_bad++; $display("FAIL gap_199 mole got %h want 00", mole); end
    tick_n(1);
    n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL gap_200 mole got %h want one-hot", mole); end
    n_cmp++; if (busy !== 1'b1 || level !== 2'd0) begin n_bad++; $display("FAIL show_entry busy=%b level=%0d want 1/0", busy, level); end
    $display("show_entry: mole=%h after 200 ticks", mole);
  endtask

  task automatic test_hit();
    logic [7:0] m;
    int h0, m0;
    m = mole;
    h0 = hits_seen;
    m0 = miss_seen;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++; if (mole !== m || busy !== 1'b1) begin n_bad++; $display("FAIL start_in_show mole=%h busy=%b want %h/1", mole, busy, m); end
    btn = m;
    cyc();
    n_cmp++; if (hit !== m) begin n_bad++; $display("FAIL hit_value got %h want %h", hit, m); end
    n_cmp++; if (mole !== 8'h00) begin n_bad++; $display("FAIL hit_clears_mole got %h want 00", mole); end
    cyc();
    n_cmp++; if (hit !== 8'h00) begin n_bad++; $display("FAIL hit_one_clk got %h want 00", hit); end
    btn = 8'h00;
    n_cmp++; if (hits_seen !== h0 + 1 || miss_seen !== m0) begin n_bad++; $display("FAIL hit_pulse_count hits=%0d misses=%0d want %0d/%0d", hits_seen, miss_seen, h0 + 1, m0); end
    tick_n(199);
    n_cmp++; if (mole !== 8'h00) begin n_bad++; $display("FAIL regap_199 mole got %h want 00", mole); end
    tick_n(1);
    n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL regap_200 mole got %h want one-hot", mole); end
    n_cmp++; if (mole === m) begin n_bad++; $display("FAIL new_hole_differs got %h want not %h", mole, m); end
    $display("hit: hit=%h, next mole=%h", m, mole);
  endtask

  task automatic test_wrong_and_held();
    logic [7:0] m2, m3, w;
    int h0, m0;
    m2 = mole;
    w = {m2[6:0], m2[7]};
    h0 = hits_seen;
    btn = w;
    cyc();
    n_cmp++; if (hit !== 8'h00 || mole !== m2) begin n_bad++; $display("FAIL wrong_btn hit=%h mole=%h want 00/%h", hit, mole, m2); end
    btn = 8'h00;
    cyc();
    n_cmp++; if (hits_seen !== h0 || miss_seen !== 0) begin n_bad++; $display("FAIL wrong_btn_pulses hits=%0d misses=%0d want %0d/0", hits_seen, miss_seen, h0); end
    btn = m2;
    cyc();
    btn = 8'h00;
    cyc();
    // hold every button through the gap into the next SHOW
    btn = 8'hFF;
    cyc();
    n_cmp++; if (hit !== 8'h00) begin n_bad++; $display("FAIL gap_press_ignored hit got %h want 00", hit); end
    h0 = hits_seen;
    tick_n(200);
    m3 = mole;
    repeat (3) cyc();
    n_cmp++; if ($onehot(mole) !== 1'b1 || mole !== m3) begin n_bad++; $display("FAIL held_mole got %h want one-hot %h", mole, m3); end
    n_cmp++; if (hits_seen !== h0) begin n_bad++; $display("FAIL held_btn_no_hit hits=%0d want %0d", hits_seen, h0); end
    btn = 8'h00;
    cyc();
    m0 = miss_seen;
    h0 = hits_seen;
    tick_n(799);
    n_cmp++; if (mole !== m3) begin n_bad++; $display("FAIL show_799 mole got %h want %h", mole, m3); end
    btn = m3;
    tick = 1'b1;
    cyc();
    n_cmp++; if (hit !== m3 || miss !== 1'b0) begin n_bad++; $display("FAIL hit_on_timeout hit=%h miss=%b want %h/0", hit, miss, m3); end
    tick = 1'b0;
    btn = 8'h00;
    cyc();
    n_cmp++; if (miss_seen !== m0 || hits_seen !== h0 + 1 || mole !== 8'h00) begin n_bad++; $display("FAIL hit_wins misses=%0d hits=%0d mole=%h want %0d/%0d/00", miss_seen, hits_seen, mole, m0, h0 + 1); end
    $display("wrong_and_held: wrong=%h ignored, held ignored, timeout-tick hit=%h", w, m3);
  endtask

  task automatic test_miss_over();
    int m0, h0;
    m0 = miss_seen;
    h0 = hits_seen;
    for (int k = 0; k < 3; k++) begin
      tick_n(200);
      n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL miss_show_%0d mole got %h want one-hot", k, mole); end
      tick_n(799);
      n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL miss_799_%0d mole got %h want one-hot", k, mole); end
      tick_n(1);
      n_cmp++; if (mole !== 8'h00 || miss_seen !== m0 + k + 1) begin n_bad++; $display("FAIL miss_timeout_%0d mole=%h misses=%0d want 00/%0d", k, mole, miss_seen, m0 + k + 1); end
    end
    n_cmp++; if (over !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL game_over over=%b busy=%b want 1/0", over, busy); end
    n_cmp++; if (hits_seen !== h0) begin n_bad++; $display("FAIL miss_no_hit hits=%0d want %0d", hits_seen, h0); end
    lvl_up = 1'b1;
    repeat (2) cyc();
    lvl_up = 1'b0;
    repeat (4) cyc();
    tick_n(300);
    n_cmp++; if (level !== 2'd0 || over !== 1'b1 || mole !== 8'h00) begin n_bad++; $display("FAIL over_holds level=%0d over=%b mole=%h want 0/1/00", level, over, mole); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++; if (over !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart over=%b busy=%b want 0/1", over, busy); end
    $display("miss_over: 3 misses -> over, restart ok");
  endtask

  task automatic test_level();
    int m0;
    tick_n(200);
    for (int k = 0; k < 4; k++) begin
      lvl_up = 1'b1;
      repeat (2) cyc();
      lvl_up = 1'b0;
      repeat (3) cyc();
    end
    cyc();
    n_cmp++; if (level !== 2'd3) begin n_bad++; $display("FAIL level_saturate got %0d want 3", level); end
    m0 = miss_seen;
    tick_n(799);
    n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL cur_show_800 mole got %h want one-hot", mole); end
    tick_n(1);
    n_cmp++; if (mole !== 8'h00 || miss_seen !== m0 + 1) begin n_bad++; $display("FAIL cur_show_end mole=%h misses=%0d want 00/%0d", mole, miss_seen, m0 + 1); end
    tick_n(200);
    tick_n(99);
    n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL lvl3_show_99 mole got %h want one-hot", mole); end
    tick_n(1);
    n_cmp++; if (mole !== 8'h00 || miss_seen !== m0 + 2 || busy !== 1'b1) begin n_bad++; $display("FAIL lvl3_show_100 mole=%h misses=%0d busy=%b want 00/%0d/1", mole, miss_seen, busy, m0 + 2); end
    $display("level: saturated at 3, next SHOW 100 ticks");
  endtask

  task automatic test_clr_mid_show();
    int m0, h0;
    tick_n(200);
    n_cmp++; if ($onehot(mole) !== 1'b1) begin n_bad++; $display("FAIL clr_pre_show mole got %h want one-hot", mole); end
    m0 = miss_seen;
    h0 = hits_seen;
    #2;
    clr = 1'b1;
    #1;
    n_cmp++; if (mole !== 8'h00 || level !== 2'd0) begin n_bad++; $display("FAIL clr_async mole=%h level=%0d want 00/0", mole, level); end
    n_cmp++; if (busy !== 1'b0 || over !== 1'b0 || hit !== 8'h00 || miss !== 1'b0) begin n_bad++; $display("FAIL clr_async_flags busy=%b over=%b hit=%h miss=%b want 0/0/00/0", busy, over, hit, miss); end
    repeat (3) cyc();
    clr = 1'b0;
    cyc();
    tick_n(250);
    n_cmp++; if (busy !== 1'b0 || mole !== 8'h00) begin n_bad++; $display("FAIL clr_idle busy=%b mole=%h want 0/00", busy, mole); end
    n_cmp++; if (miss_seen !== m0 || hits_seen !== h0) begin n_bad++; $display("FAIL clr_no_pulse misses=%0d hits=%0d want %0d/%0d", miss_seen, hits_seen, m0, h0); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_restart busy got %b want 1", busy); end
    $display("clr_mid_show: outputs dropped, idle until start");
  endtask

  initial begin
    test_reset();
    test_show_entry();
    test_hit();
    test_wrong_and_held();
    test_miss_over();
    test_level();
    test_clr_mid_show();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
